snake_head_stepper: RTL and testbench
=====================================

Name: snake_head_stepper

Overview:
- Consumer end of the mouse-steering path: samples the `direction` value held by the steering block on each game tick, the falling edge of `clk_divided`.
- Advances the snake head one grid cell per tick, with wrap-around or wall-crash handling.
- Emits a one-cycle step pulse and the new head coordinates to the body/board logic.
- Sits between the steering block and the snake body memory in the snake game core.

Parameters:
- GRID_W, 32, grid width in cells.
- GRID_H, 24, grid height in cells.
- START_X, 16, head x after reset and after restart.
- START_Y, 12, head y after reset and after restart.
- WRAP, 1, 1 = edges wrap to the opposite side; 0 = leaving the grid is a crash.
- XW, $clog2(GRID_W), x coordinate width (derived).
- YW, $clog2(GRID_H), y coordinate width (derived).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clk_divided  input  1  game tick clock, sampled in the clk domain; the falling edge is a tick.
- enable  input  1  game running; low = pause (ticks ignored).
- restart  input  1  one-cycle pulse; returns the head to the start cell and clears the crash state.
- dir  input  direction  current heading from steering (snake_pkg enum).
- head_x  output  XW  head column.
- head_y  output  YW  head row.
- dir_used  output  direction  heading applied on the last step.
- step_valid  output  1  one-cycle pulse; head_x/head_y hold a new position.
- crashed  output  1  sticky wall-crash flag (WRAP=0 only).
- step_count  output  16  number of steps taken since reset or restart.

Behaviour:
- Reset values: head_x=START_X, head_y=START_Y, dir_used=UP, step_valid=0, crashed=0, step_count=0, clk_div_prev=0, state=IDLE.
- Tick detection:
  - clk_div_prev is registered every clk, including during rst.
  - tick = clk_div_prev & ~clk_divided, combinational.
  - This is the same edge on which steering re-arms, so dir is sampled in the cycle tick is high.
- Coordinates: UP = y-1, DOWN = y+1, LEFT = x-1, RIGHT = x+1. y=0 is the top row.
- States:
  - IDLE: head held at the start cell. enable=1 -> RUN on the next clk; no step on that cycle.
  - RUN: on tick, compute the next cell from dir.
    - In range -> head updates next clk; dir_used<=dir; step_valid=1 that cycle; step_count+1.
    - step_count saturates at 16'hFFFF.
    - enable=0 -> IDLE; head is kept, not reset.
  - CRASHED: head frozen; step_valid never asserted; crashed=1.
- Latency: exactly one clk from the tick cycle to the updated head_x/head_y, which coincide with step_valid=1.
- Wrap, WRAP=1:
  - x=0 LEFT -> GRID_W-1; x=GRID_W-1 RIGHT -> 0.
  - y=0 UP -> GRID_H-1; y=GRID_H-1 DOWN -> 0.
  - Use explicit compare against GRID_W-1/GRID_H-1, not modulo 2^XW, since the grid need not be a power of two.
- Crash, WRAP=0:
  - An out-of-range move leaves the head unchanged, sets crashed=1 and goes to CRASHED.
  - No step_valid and no count increment for that tick.
- Invalid dir encoding: treated as UP.
- restart:
  - In any state: head <= START, step_count<=0, crashed<=0, dir_used<=UP, state -> IDLE.
  - restart has priority over a simultaneous tick; no step_valid is produced.
- rst: has priority over everything, and mid-step discards any pending update.
- enable=0 on the same cycle as tick in RUN: the tick is ignored; no step.
- A tick in IDLE is ignored, including on the cycle enable rises.

Decomposition:
- snake_pkg:
  - the existing `direction` enum;
  - default GRID_W/GRID_H and start-cell localparams;
  - the STATE_T enum {IDLE, RUN, CRASHED} for this block.
- Sub-module `snake_next_cell`: combinational; (x, y, dir, WRAP) -> (nx, ny, out_of_range). It is reused by collision and food logic.

Test Plan:
- Reset, enable=1, dir=RIGHT, 3 ticks -> head (17,12),(18,12),(19,12); step_valid pulses 3× one clk after each falling edge; step_count=3.
- WRAP=1: head (31,5), dir=RIGHT, tick -> (0,5). Head (4,0), dir=UP, tick -> (4,23).
- WRAP=0: head (0,7), dir=LEFT, tick -> head stays (0,7); crashed=1; no step_valid; later ticks ignored. Then restart -> (16,12), crashed=0, IDLE.
- Steering handshake: dir changes UP->LEFT between ticks -> the next step uses LEFT and dir_used=LEFT. dir changing in the same cycle as the tick -> the value present in the tick cycle is used.
- enable dropped for 2 ticks in RUN -> no head change, step_count frozen. Re-enable -> stepping resumes from the held position.
- restart and tick in the same cycle -> head=(16,12), step_count=0, no step_valid. rst asserted mid-run -> all outputs return to reset values next clk.

Source files
------------

// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared types and default geometry for the snake game core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } direction;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CRASHED = 2'd2
    } STATE_T;

    localparam int c_grid_w_default  = 32;
    localparam int c_grid_h_default  = 24;
    localparam int c_start_x_default = 16;
    localparam int c_start_y_default = 12;

endpackage

`default_nettype wire

// File: rtl/snake_head_stepper_if.sv
// ============================================================================
// Module      : snake_head_stepper_if
// Description : Steering-to-head and head-to-board signal bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface snake_head_stepper_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    import snake_pkg::*;

    direction        dir;
    logic [XW-1:0]   head_x;
    logic [YW-1:0]   head_y;
    direction        dir_used;
    logic            step_valid;
    logic            crashed;
    logic [15:0]     step_count;

    modport master (
        output dir,
        input  head_x, head_y, dir_used, step_valid, crashed, step_count
    );

    modport slave (
        input  dir,
        output head_x, head_y, dir_used, step_valid, crashed, step_count
    );

endinterface

`default_nettype wire

// File: rtl/snake_next_cell.sv
// ============================================================================
// Module      : snake_next_cell
// Description : Combinational neighbour-cell calculator with wrap or range flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module snake_next_cell
    import snake_pkg::*;
#(
    parameter int GRID_W = c_grid_w_default,
    parameter int GRID_H = c_grid_h_default,
    parameter int WRAP   = 1,
    parameter int XW     = $clog2(GRID_W),
    parameter int YW     = $clog2(GRID_H)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  direction      dir,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny,
    output logic          out_of_range
);

    // Edges compared explicitly: the grid is not necessarily a power of two.
    always_comb begin
        nx           = x;
        ny           = y;
        out_of_range = 1'b0;
        case (dir)
            DOWN: begin
                if (y == YW'(GRID_H - 1)) begin
                    if (WRAP != 0) ny = '0;
                    else           out_of_range = 1'b1;
                end else begin
                    ny = y + YW'(1);
                end
            end
            LEFT: begin
                if (x == '0) begin
                    if (WRAP != 0) nx = XW'(GRID_W - 1);
                    else           out_of_range = 1'b1;
                end else begin
                    nx = x - XW'(1);
                end
            end
            RIGHT: begin
                if (x == XW'(GRID_W - 1)) begin
                    if (WRAP != 0) nx = '0;
                    else           out_of_range = 1'b1;
                end else begin
                    nx = x + XW'(1);
                end
            end
            default: begin
                if (y == '0) begin
                    if (WRAP != 0) ny = YW'(GRID_H - 1);
                    else           out_of_range = 1'b1;
                end else begin
                    ny = y - YW'(1);
                end
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/snake_head_stepper.sv
// ============================================================================
// Module      : snake_head_stepper
// Description : Advances the snake head one cell per falling edge of clk_divided.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int GRID_W  = c_grid_w_default,
    parameter int GRID_H  = c_grid_h_default,
    parameter int START_X = c_start_x_default,
    parameter int START_Y = c_start_y_default,
    parameter int WRAP    = 1,
    parameter int XW      = $clog2(GRID_W),
    parameter int YW      = $clog2(GRID_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_divided,
    input  logic                 enable,
    input  logic                 restart,
    snake_head_stepper_if.slave  bus
);

    STATE_T         r_state;
    STATE_T         w_state_next;
    logic           r_clk_div_prev;
    logic [XW-1:0]  r_head_x;
    logic [YW-1:0]  r_head_y;
    direction       r_dir_used;
    logic           r_step_valid;
    logic           r_crashed;
    logic [15:0]    r_step_count;

    logic           w_tick;
    logic           w_do_step;
    logic           w_do_crash;
    logic [XW-1:0]  w_nx;
    logic [YW-1:0]  w_ny;
    logic           w_oor;

    assign w_tick = r_clk_div_prev & ~clk_divided;

    snake_next_cell #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .WRAP   (WRAP),
        .XW     (XW),
        .YW     (YW)
    ) u_next_cell (
        .x            (r_head_x),
        .y            (r_head_y),
        .dir          (bus.dir),
        .nx           (w_nx),
        .ny           (w_ny),
        .out_of_range (w_oor)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_do_step    = 1'b0;
        w_do_crash   = 1'b0;
        if (restart) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) w_state_next = RUN;
                end
                RUN: begin
                    if (!enable) begin
                        w_state_next = IDLE;
                    end else if (w_tick) begin
                        if (w_oor) begin
                            w_do_crash   = 1'b1;
                            w_state_next = CRASHED;
                        end else begin
                            w_do_step = 1'b1;
                        end
                    end
                end
                CRASHED: w_state_next = CRASHED;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The edge detector keeps tracking clk_divided through reset.
    always_ff @(posedge clk) begin
        r_clk_div_prev <= clk_divided;
        if (rst || restart) begin
            r_head_x     <= XW'(START_X);
            r_head_y     <= YW'(START_Y);
            r_dir_used   <= UP;
            r_step_valid <= 1'b0;
            r_crashed    <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_step_valid <= w_do_step;
            if (w_do_step) begin
                r_head_x   <= w_nx;
                r_head_y   <= w_ny;
                r_dir_used <= bus.dir;
                if (r_step_count != 16'hFFFF) r_step_count <= r_step_count + 16'd1;
            end
            if (w_do_crash) r_crashed <= 1'b1;
        end
    end

    assign bus.head_x     = r_head_x;
    assign bus.head_y     = r_head_y;
    assign bus.dir_used   = r_dir_used;
    assign bus.step_valid = r_step_valid;
    assign bus.crashed    = r_crashed;
    assign bus.step_count = r_step_count;

endmodule

`default_nettype wire

// File: tb/tb_snake_head_stepper.sv
// ============================================================================
// Module      : tb_snake_head_stepper
// Description : Directed bench driving a wrapping and a walled stepper in lockstep.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_snake_head_stepper;
    import snake_pkg::*;

    logic clk;
    logic rst;
    logic clk_divided;
    logic enable;
    logic restart;

    int n_checks;
    int n_fail;

    snake_head_stepper_if #(.XW(5), .YW(5)) w_if ();
    snake_head_stepper_if #(.XW(5), .YW(5)) n_if ();

    snake_head_stepper #(.WRAP(1)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .clk_divided (clk_divided),
        .enable      (enable),
        .restart     (restart),
        .bus         (w_if.slave)
    );

    snake_head_stepper #(.WRAP(0)) u_wall (
        .clk         (clk),
        .rst         (rst),
        .clk_divided (clk_divided),
        .enable      (enable),
        .restart     (restart),
        .bus         (n_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk_divided period; dir changes in the very cycle the falling edge is seen.
    task automatic tick(input direction d, input bit chk, input bit exp_w, input bit exp_n);
        @(negedge clk);
        clk_divided = 1'b1;
        @(negedge clk);
        clk_divided = 1'b0;
        w_if.dir    = d;
        n_if.dir    = d;
        if (chk) begin
            check("sv_w_before", w_if.step_valid, 0);
            check("sv_n_before", n_if.step_valid, 0);
        end
        @(negedge clk);
        if (chk) begin
            check("sv_w", w_if.step_valid, exp_w);
            check("sv_n", n_if.step_valid, exp_n);
        end
        @(negedge clk);
        if (chk) begin
            check("sv_w_after", w_if.step_valid, 0);
            check("sv_n_after", n_if.step_valid, 0);
        end
    endtask

    task automatic quiet(input direction d, input int n);
        for (int i = 0; i < n; i++) tick(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_all(input int xw, input int yw, input int cw,
                              input int xn, input int yn, input int cn, input bit crn);
        check("w_x", w_if.head_x, xw);
        check("w_y", w_if.head_y, yw);
        check("w_count", w_if.step_count, cw);
        check("w_crashed", w_if.crashed, 0);
        check("n_x", n_if.head_x, xn);
        check("n_y", n_if.head_y, yn);
        check("n_count", n_if.step_count, cn);
        check("n_crashed", n_if.crashed, crn);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        clk_divided = 1'b0;
        enable      = 1'b0;
        restart     = 1'b0;
        w_if.dir    = UP;
        n_if.dir    = UP;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        expect_all(16, 12, 0, 16, 12, 0, 0);
        check("rst_dir_used", w_if.dir_used, UP);
        check("rst_sv", w_if.step_valid, 0);

        // Basic stepping to the right.
        enable = 1'b1;
        tick(RIGHT, 1'b1, 1'b1, 1'b1);
        expect_all(17, 12, 1, 17, 12, 1, 0);
        tick(RIGHT, 1'b1, 1'b1, 1'b1);
        tick(RIGHT, 1'b1, 1'b1, 1'b1);
        expect_all(19, 12, 3, 19, 12, 3, 0);
        check("dir_used_right", w_if.dir_used, RIGHT);

        // Heading changes between ticks and within the tick cycle.
        tick(UP, 1'b1, 1'b1, 1'b1);
        w_if.dir = LEFT;
        n_if.dir = LEFT;
        repeat (2) @(negedge clk);
        tick(LEFT, 1'b1, 1'b1, 1'b1);
        expect_all(18, 11, 5, 18, 11, 5, 0);
        check("dir_used_left", w_if.dir_used, LEFT);
        tick(DOWN, 1'b1, 1'b1, 1'b1);
        check("dir_used_down", n_if.dir_used, DOWN);
        expect_all(18, 12, 6, 18, 12, 6, 0);

        // Pause for two ticks, then resume from the held cell.
        enable = 1'b0;
        tick(RIGHT, 1'b1, 1'b0, 1'b0);
        tick(RIGHT, 1'b1, 1'b0, 1'b0);
        expect_all(18, 12, 6, 18, 12, 6, 0);
        enable = 1'b1;
        tick(RIGHT, 1'b1, 1'b1, 1'b1);
        expect_all(19, 12, 7, 19, 12, 7, 0);

        // Right edge: wrap vs wall crash.
        quiet(RIGHT, 12);
        quiet(UP, 7);
        expect_all(31, 5, 26, 31, 5, 26, 0);
        tick(RIGHT, 1'b1, 1'b1, 1'b0);
        expect_all(0, 5, 27, 31, 5, 26, 1);
        tick(LEFT, 1'b1, 1'b1, 1'b0);
        expect_all(31, 5, 28, 31, 5, 26, 1);

        pulse_restart();
        expect_all(16, 12, 0, 16, 12, 0, 0);
        check("restart_dir_used", n_if.dir_used, UP);

        // Top edge.
        quiet(LEFT, 12);
        quiet(UP, 12);
        expect_all(4, 0, 24, 4, 0, 24, 0);
        tick(UP, 1'b1, 1'b1, 1'b0);
        expect_all(4, 23, 25, 4, 0, 24, 1);

        // Left edge at (0,7).
        pulse_restart();
        quiet(LEFT, 16);
        quiet(UP, 5);
        expect_all(0, 7, 21, 0, 7, 21, 0);
        tick(LEFT, 1'b1, 1'b1, 1'b0);
        expect_all(31, 7, 22, 0, 7, 21, 1);
        tick(DOWN, 1'b1, 1'b1, 1'b0);
        expect_all(31, 8, 23, 0, 7, 21, 1);
        pulse_restart();
        expect_all(16, 12, 0, 16, 12, 0, 0);

        // Restart coinciding with a tick.
        tick(RIGHT, 1'b1, 1'b1, 1'b1);
        expect_all(17, 12, 1, 17, 12, 1, 0);
        @(negedge clk);
        clk_divided = 1'b1;
        @(negedge clk);
        clk_divided = 1'b0;
        restart     = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_tick_sv_w", w_if.step_valid, 0);
        check("restart_tick_sv_n", n_if.step_valid, 0);
        expect_all(16, 12, 0, 16, 12, 0, 0);

        // Reset asserted in a tick cycle mid-run.
        tick(RIGHT, 1'b1, 1'b1, 1'b1);
        tick(DOWN, 1'b1, 1'b1, 1'b1);
        expect_all(17, 13, 2, 17, 13, 2, 0);
        @(negedge clk);
        clk_divided = 1'b1;
        @(negedge clk);
        clk_divided = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        check("rst_mid_sv", w_if.step_valid, 0);
        check("rst_mid_dir_used", w_if.dir_used, UP);
        expect_all(16, 12, 0, 16, 12, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
